// File: rtl/wb_seq_ctrl_if.sv
// Handshake and write-back bus between the MEM stage, data memory and the WB sequencer.
interface wb_seq_ctrl_if;
    logic       ms_valid_in;
    logic [2:0] ms_wb_mux_sel_in;
    logic       ms_rf_wr_en_in;
    logic [4:0] ms_rd_addr_in;
    logic       dmem_rsp_valid_in;
    logic       ms_ready_out;
    logic [2:0] wb_mux_sel_reg_out;
    logic       rf_wr_en_out;
    logic [4:0] rf_rd_addr_out;
    logic       wb_busy_out;
    logic       bus_err_out;

    modport master (
        output ms_valid_in, ms_wb_mux_sel_in, ms_rf_wr_en_in, ms_rd_addr_in, dmem_rsp_valid_in,
        input  ms_ready_out, wb_mux_sel_reg_out, rf_wr_en_out, rf_rd_addr_out, wb_busy_out, bus_err_out
    );

    modport slave (
        input  ms_valid_in, ms_wb_mux_sel_in, ms_rf_wr_en_in, ms_rd_addr_in, dmem_rsp_valid_in,
        output ms_ready_out, wb_mux_sel_reg_out, rf_wr_en_out, rf_rd_addr_out, wb_busy_out, bus_err_out
    );
endinterface

// File: rtl/wb_seq_ctrl.sv
// RV32I write-back sequencer: latches a retiring instruction, waits for load/CSR data, strobes the RF.
// Optional load-wait timeout with bus error pulse is enabled by defining LOAD_TIMEOUT_EN.
module wb_seq_ctrl #(
    parameter int CSR_LAT        = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic        clk_in,
    input logic        reset_in,
    wb_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, WAIT_CSR, COMMIT} state_t;

    localparam logic [3:0] CSR_LOAD = (CSR_LAT > 0) ? 4'(CSR_LAT - 1) : 4'd0;

    state_t     state, state_next;
    logic       ready, busy, accept, timeout;
    logic [2:0] sel_norm;
    logic [2:0] sel_q;
    logic [4:0] rd_q;
    logic       we_q;
    logic [3:0] csr_cnt;

    always_ff @(posedge clk_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = (state == IDLE) || (state == COMMIT);
        busy       = (state == WAIT_LOAD) || (state == WAIT_CSR);
        accept     = bus.ms_valid_in & ready;
        sel_norm   = (bus.ms_wb_mux_sel_in[2:1] == 2'b11) ? 3'b000 : bus.ms_wb_mux_sel_in;
        case (state)
            IDLE, COMMIT: begin
                if (!accept)                             state_next = IDLE;
                else if (sel_norm == 3'b001)             state_next = WAIT_LOAD;
                else if (sel_norm == 3'b011 && CSR_LAT > 0) state_next = WAIT_CSR;
                else                                     state_next = COMMIT;
            end
            // A response in the timeout cycle still commits normally.
            WAIT_LOAD: begin
                if (bus.dmem_rsp_valid_in) state_next = COMMIT;
                else if (timeout)          state_next = IDLE;
            end
            WAIT_CSR: begin
                if (csr_cnt == 4'd0) state_next = COMMIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sel_q <= 3'b000;
            rd_q  <= 5'd0;
            we_q  <= 1'b0;
        end else if (accept) begin
            sel_q <= sel_norm;
            rd_q  <= bus.ms_rd_addr_in;
            we_q  <= bus.ms_rf_wr_en_in & (bus.ms_rd_addr_in != 5'd0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in)
            csr_cnt <= 4'd0;
        else if (accept && state_next == WAIT_CSR)
            csr_cnt <= CSR_LOAD;
        else if (state == WAIT_CSR && csr_cnt != 4'd0)
            csr_cnt <= csr_cnt - 4'd1;
    end

`ifdef LOAD_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       bus_err_q;

    // Counter sits at zero outside WAIT_LOAD, so it is clear on every entry.
    assign timeout = (state == WAIT_LOAD) && !bus.dmem_rsp_valid_in &&
                     (to_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            to_cnt    <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (state != WAIT_LOAD)
                to_cnt <= 8'd0;
            else if (!bus.dmem_rsp_valid_in)
                to_cnt <= to_cnt + 8'd1;
        end
    end

    assign bus.bus_err_out = bus_err_q;
`else
    assign timeout         = 1'b0;
    assign bus.bus_err_out = 1'b0;
`endif

    assign bus.ms_ready_out       = ready;
    assign bus.wb_busy_out        = busy;
    assign bus.rf_wr_en_out       = (state == COMMIT) & we_q;
    assign bus.wb_mux_sel_reg_out = sel_q;
    assign bus.rf_rd_addr_out     = rd_q;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Bench for wb_seq_ctrl: two instances (CSR_LAT=2 and CSR_LAT=0) against a transaction-timing model.
module tb_wb_seq_ctrl;
    localparam int TO = 4;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [2:0] sel;
        logic       we;
        logic [4:0] rd;
        logic       rsp;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic t_valid = 1'b0;
    logic [2:0] t_sel = 3'd0;
    logic t_we = 1'b0;
    logic [4:0] t_rd = 5'd0;
    logic t_rsp = 1'b0;

    always #5 clk = ~clk;

    wb_seq_ctrl_if bus0();
    wb_seq_ctrl_if bus1();

    assign bus0.ms_valid_in = t_valid;
    assign bus0.ms_wb_mux_sel_in = t_sel;
    assign bus0.ms_rf_wr_en_in = t_we;
    assign bus0.ms_rd_addr_in = t_rd;
    assign bus0.dmem_rsp_valid_in = t_rsp;
    assign bus1.ms_valid_in = t_valid;
    assign bus1.ms_wb_mux_sel_in = t_sel;
    assign bus1.ms_rf_wr_en_in = t_we;
    assign bus1.ms_rd_addr_in = t_rd;
    assign bus1.dmem_rsp_valid_in = t_rsp;

    wb_seq_ctrl #(.CSR_LAT(2), .TIMEOUT_CYCLES(TO)) dut0 (.clk_in(clk), .reset_in(rst), .bus(bus0.slave));
    wb_seq_ctrl #(.CSR_LAT(0), .TIMEOUT_CYCLES(TO)) dut1 (.clk_in(clk), .reset_in(rst), .bus(bus1.slave));

    // Observed vector: {ready, sel[2:0], wr, rd[4:0], busy, err}
    logic [11:0] obs [2];
    assign obs[0] = {bus0.ms_ready_out, bus0.wb_mux_sel_reg_out, bus0.rf_wr_en_out,
                     bus0.rf_rd_addr_out, bus0.wb_busy_out, bus0.bus_err_out};
    assign obs[1] = {bus1.ms_ready_out, bus1.wb_mux_sel_reg_out, bus1.rf_wr_en_out,
                     bus1.rf_rd_addr_out, bus1.wb_busy_out, bus1.bus_err_out};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: one pending instruction per instance and the cycle it is due to commit.
    bit         pend [2];
    int         kind [2];      // 0 single-cycle, 1 CSR, 2 load
    int         acc_c [2];
    int         commit_at [2];
    int         err_at [2];
    bit         m_we [2];
    logic [2:0] o_sel [2];
    logic [4:0] o_rd [2];
    bit         e_commit [2];
    bit         e_ready [2];
    logic [11:0] expv [2];

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic stim_t S(logic r, logic v, logic [2:0] sel, logic we, logic [4:0] rd, logic rsp);
        stim_t s;
        s = '{rst: r, v: v, sel: sel, we: we, rd: rd, rsp: rsp};
        return s;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; kind[d] = 0; acc_c[d] = 0; commit_at[d] = -1; err_at[d] = -1;
            m_we[d] = 1'b0; o_sel[d] = 3'd0; o_rd[d] = 5'd0;
        end
    endtask

    task automatic model_eval();
        for (int d = 0; d < 2; d++) begin
            e_commit[d] = pend[d] && (commit_at[d] == cyc);
            e_ready[d]  = !pend[d] || e_commit[d];
            expv[d] = {e_ready[d], o_sel[d], e_commit[d] && m_we[d], o_rd[d],
                       pend[d] && !e_commit[d], err_at[d] == cyc};
        end
    endtask

    task automatic model_update();
        logic [2:0] s;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pend[d] = 1'b0; commit_at[d] = -1; err_at[d] = -1;
                m_we[d] = 1'b0; o_sel[d] = 3'd0; o_rd[d] = 5'd0;
                continue;
            end
            if (e_commit[d]) begin
                pend[d] = 1'b0;
            end else if (pend[d] && kind[d] == 2) begin
                if (t_rsp) commit_at[d] = cyc + 1;
`ifdef LOAD_TIMEOUT_EN
                else if (cyc - acc_c[d] >= TO) begin
                    pend[d] = 1'b0;
                    err_at[d] = cyc + 1;
                end
`endif
            end
            if (t_valid && e_ready[d]) begin
                s = (t_sel >= 3'd6) ? 3'd0 : t_sel;
                o_sel[d] = s;
                o_rd[d] = t_rd;
                m_we[d] = t_we && (t_rd != 5'd0);
                pend[d] = 1'b1;
                acc_c[d] = cyc;
                if (s == 3'd1) begin
                    kind[d] = 2; commit_at[d] = -1;
                end else if (s == 3'd3) begin
                    kind[d] = 1; commit_at[d] = cyc + 1 + lat_of(d);
                end else begin
                    kind[d] = 0; commit_at[d] = cyc + 1;
                end
            end
        end
    endtask

    task automatic apply(stim_t s);
        rst = s.rst; t_valid = s.v; t_sel = s.sel; t_we = s.we; t_rd = s.rd; t_rsp = s.rsp;
        model_eval();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        apply(S(1, 0, 0, 0, 0, 0));
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(S(1, 1, 3'd4, 1, 5'd9, 1));
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== 12'b1_000_0_00000_0_0) begin
                    n_fail++;
                    $display("FAIL reset_state dut%0d cyc%0d: got %b want %b", d, cyc, obs[d], 12'b1_000_0_00000_0_0);
                end
            end
            tick();
        end
    endtask

    task automatic test_alu();
        stim_t q[$];
        q = '{S(0,1,3'd0,1,5'd5,0), S(0,0,0,0,0,0), S(0,0,0,0,0,0)};
        foreach (q[i]) begin
            apply(q[i]);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL alu step%0d dut%0d: got %b want %b", i, d, obs[d], expv[d]);
                end
            end
            if (i == 1) begin
                n_chk++;
                if (obs[0] !== 12'b1_000_1_00101_0_0) begin
                    n_fail++;
                    $display("FAIL alu_commit: got %b want %b", obs[0], 12'b1_000_1_00101_0_0);
                end
            end
            tick();
        end
    endtask

    task automatic test_load();
        stim_t q[$];
        q = '{S(0,1,3'd1,1,5'd7,1), S(0,1,3'd0,1,5'd2,0), S(0,0,0,0,0,0),
              S(0,0,0,0,0,1), S(0,0,0,0,0,0), S(0,0,0,0,0,1), S(0,0,0,0,0,0)};
        foreach (q[i]) begin
            apply(q[i]);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL load step%0d dut%0d: got %b want %b", i, d, obs[d], expv[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_csr();
        stim_t q[$];
        q = '{S(0,1,3'd3,1,5'd9,0), S(0,1,3'd2,1,5'd4,0), S(0,0,0,0,0,0),
              S(0,0,0,0,0,0), S(0,0,0,0,0,0), S(0,0,0,0,0,0)};
        foreach (q[i]) begin
            apply(q[i]);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL csr step%0d dut%0d: got %b want %b", i, d, obs[d], expv[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        q = '{S(0,1,3'd4,1,5'd1,0), S(0,1,3'd2,1,5'd0,0), S(0,1,3'd7,1,5'd3,0),
              S(0,0,0,0,0,0), S(0,0,0,0,0,0)};
        foreach (q[i]) begin
            apply(q[i]);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL b2b step%0d dut%0d: got %b want %b", i, d, obs[d], expv[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t q[$];
        q = '{S(0,1,3'd1,1,5'd12,0), S(0,0,0,0,0,0), S(1,0,0,0,0,1),
              S(0,0,0,0,0,1), S(0,0,0,0,0,0)};
        foreach (q[i]) begin
            apply(q[i]);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL rst_wait step%0d dut%0d: got %b want %b", i, d, obs[d], expv[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        stim_t q[$];
        q.push_back(S(0,1,3'd1,1,5'd6,0));
        for (int i = 0; i < 6; i++) q.push_back(S(0,0,0,0,0,0));
        q.push_back(S(0,1,3'd1,1,5'd8,0));
        for (int i = 0; i < 3; i++) q.push_back(S(0,0,0,0,0,0));
        q.push_back(S(0,0,0,0,0,1));
        q.push_back(S(0,0,0,0,0,0));
        q.push_back(S(0,0,0,0,0,1));
        q.push_back(S(0,0,0,0,0,0));
        foreach (q[i]) begin
            apply(q[i]);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL timeout step%0d dut%0d: got %b want %b", i, d, obs[d], expv[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 400; i++) begin
            s = S(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0));
            apply(s);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs[d] !== expv[d]) begin
                    n_fail++;
                    $display("FAIL random cyc%0d dut%0d: got %b want %b", cyc, d, obs[d], expv[d]);
                end
            end
            tick();
        end
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_alu();
        test_load();
        test_csr();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
